// File: rtl/pwm_shift_pkg.sv
// pwm_shift_pkg: shared mode, direction and FSM state encodings for the pattern shifter
package pwm_shift_pkg;
  localparam logic [1:0] MODE_ROT = 2'b00;
  localparam logic [1:0] MODE_LOG = 2'b01;
  localparam logic [1:0] MODE_ARI = 2'b10;
  localparam logic DIR_LEFT = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/shift_step.sv
// shift_step: one-position rotate/logical/arithmetic shift of a WIDTH-bit value
module shift_step
  import pwm_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] next
);
  logic fill_l, fill_r;
  // mode 11 falls through to rotate
  assign fill_l = (mode == MODE_LOG) ? ser_in : (mode == MODE_ARI) ? 1'b0 : value[WIDTH-1];
  assign fill_r = (mode == MODE_LOG) ? ser_in : (mode == MODE_ARI) ? value[WIDTH-1] : value[0];
  assign next = (dir == DIR_RIGHT) ? {fill_r, value[WIDTH-1:1]} : {value[WIDTH-2:0], fill_l};
endmodule

// File: rtl/pattern_shifter.sv
// pattern_shifter: load/shift register with single-step and tick-paced counted burst shifting
module pattern_shifter
  import pwm_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             step,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             tick,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [CNT_W-1:0] rem;
  logic l_dir;
  logic [1:0] l_mode;
  logic s_dir;
  logic [1:0] s_mode;
  logic [WIDTH-1:0] nxt;
  // a running burst ignores live dir/mode and uses the values latched at start
  assign busy = (state == ST_RUN);
  assign s_dir = busy ? l_dir : dir;
  assign s_mode = busy ? l_mode : mode;
  assign ser_out = (s_dir == DIR_RIGHT) ? data_out[0] : data_out[WIDTH-1];
  shift_step #(.WIDTH(WIDTH)) u_step (
    .value(data_out), .dir(s_dir), .mode(s_mode), .ser_in(ser_in), .next(nxt)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      state <= ST_IDLE;
      rem <= '0;
      l_dir <= 1'b0;
      l_mode <= 2'b00;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        data_out <= data_in;
        state <= ST_IDLE;
        rem <= '0;
      end else if (state == ST_IDLE) begin
        if (start) begin
          if (count == '0) done <= 1'b1;
          else begin
            state <= ST_RUN;
            rem <= count;
            l_dir <= dir;
            l_mode <= mode;
          end
        end else if (step) data_out <= nxt;
      end else if (tick) begin
        data_out <= nxt;
        rem <= rem - 1'b1;
        if (rem == CNT_W'(1)) begin
          state <= ST_IDLE;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pattern_shifter.sv
// tb_pattern_shifter: directed scoreboard bench for pattern_shifter
module tb_pattern_shifter;
  logic clk = 1'b0;
  logic rst, load, step, start, tick, dir, ser_in;
  logic [7:0] data_in, count, data_out;
  logic [1:0] mode;
  logic ser_out, busy, done;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    string tag;
    logic [7:0] v;
  } exp_t;
  exp_t exp_q[$];

  pattern_shifter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .load(load), .data_in(data_in), .step(step),
    .start(start), .count(count), .tick(tick), .dir(dir), .mode(mode),
    .ser_in(ser_in), .data_out(data_out), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [7:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h with no expectation", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic b, input logic dn);
    expect_val({tag, "_data"}, d);
    expect_val({tag, "_busy"}, 8'(b));
    expect_val({tag, "_done"}, 8'(dn));
    observe(data_out);
    observe(8'(busy));
    observe(8'(done));
  endtask

  function automatic logic [7:0] ror8(input logic [7:0] v, input int n);
    logic [15:0] w;
    w = {v, v} >> (n % 8);
    return w[7:0];
  endfunction

  initial begin
    rst = 1'b1; load = 1'b0; step = 1'b0; start = 1'b0; tick = 1'b0;
    dir = 1'b0; ser_in = 1'b0; data_in = 8'h00; count = 8'h00; mode = 2'b00;
    cyc(); cyc();
    rst = 1'b0;
    check_all("reset", 8'h00, 1'b0, 1'b0);
    expect_val("reset_ser_out", 8'h00); observe(8'(ser_out));

    // single rotate-left step
    load = 1'b1; data_in = 8'hB4; cyc(); load = 1'b0;
    expect_val("t1_ser_out_before", 8'h01); observe(8'(ser_out));
    step = 1'b1; dir = 1'b0; mode = 2'b00; cyc(); step = 1'b0;
    check_all("t1_rot_left", 8'h69, 1'b0, 1'b0);

    // logical and arithmetic steps
    load = 1'b1; data_in = 8'h81; cyc(); load = 1'b0;
    dir = 1'b1; mode = 2'b01; ser_in = 1'b1;
    expect_val("t2_ser_out_right", 8'h01); observe(8'(ser_out));
    step = 1'b1; cyc(); step = 1'b0;
    expect_val("t2_log_right", 8'hC0); observe(data_out);
    load = 1'b1; data_in = 8'h81; cyc(); load = 1'b0;
    mode = 2'b10; ser_in = 1'b0; step = 1'b1; cyc(); step = 1'b0;
    expect_val("t2_ari_right", 8'hC0); observe(data_out);
    load = 1'b1; data_in = 8'h81; cyc(); load = 1'b0;
    dir = 1'b0; step = 1'b1; cyc(); step = 1'b0;
    expect_val("t2_ari_left", 8'h02); observe(data_out);

    // paced burst, tick every other cycle
    load = 1'b1; data_in = 8'h01; cyc(); load = 1'b0;
    start = 1'b1; count = 8'd3; dir = 1'b0; mode = 2'b00; cyc(); start = 1'b0;
    check_all("t3_start", 8'h01, 1'b1, 1'b0);
    tick = 1'b1; cyc(); check_all("t3_tick1", 8'h02, 1'b1, 1'b0);
    tick = 1'b0; cyc(); check_all("t3_hold1", 8'h02, 1'b1, 1'b0);
    tick = 1'b1; cyc(); check_all("t3_tick2", 8'h04, 1'b1, 1'b0);
    tick = 1'b0; cyc(); check_all("t3_hold2", 8'h04, 1'b1, 1'b0);
    tick = 1'b1; cyc(); check_all("t3_last", 8'h08, 1'b0, 1'b1);
    tick = 1'b0; cyc(); check_all("t3_after", 8'h08, 1'b0, 1'b0);

    // full rotate-right circle, live dir/mode changes and start/step ignored
    load = 1'b1; data_in = 8'hA5; cyc(); load = 1'b0;
    start = 1'b1; count = 8'd8; dir = 1'b1; mode = 2'b00; tick = 1'b1; cyc();
    start = 1'b0; dir = 1'b0; mode = 2'b01; ser_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin start = 1'b1; step = 1'b1; count = 8'd2; end
      if (i == 4) begin start = 1'b0; step = 1'b0; end
      cyc();
      check_all($sformatf("t4_shift%0d", i), ror8(8'hA5, i), i < 8, i == 8);
      if (i < 8) begin
        expect_val($sformatf("t4_ser_out%0d", i), 8'(ror8(8'hA5, i) & 8'h01));
        observe(8'(ser_out));
      end
    end
    tick = 1'b0; cyc(); check_all("t4_after", 8'hA5, 1'b0, 1'b0);

    // abort by load, then zero-count start
    start = 1'b1; count = 8'd5; dir = 1'b0; mode = 2'b00; tick = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    expect_val("t5_two_shifts", 8'h96); observe(data_out);
    load = 1'b1; data_in = 8'h3C; cyc(); load = 1'b0;
    check_all("t5_abort", 8'h3C, 1'b0, 1'b0);
    cyc(); check_all("t5_no_done", 8'h3C, 1'b0, 1'b0);
    start = 1'b1; count = 8'd0; cyc(); start = 1'b0;
    check_all("t5_zero_count", 8'h3C, 1'b0, 1'b1);
    cyc(); check_all("t5_zero_after", 8'h3C, 1'b0, 1'b0);

    // reset mid-burst
    start = 1'b1; count = 8'd10; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    expect_val("t6_pre_reset", 8'hE1); observe(data_out);
    rst = 1'b1; cyc(); rst = 1'b0;
    check_all("t6_reset", 8'h00, 1'b0, 1'b0);
    expect_val("t6_ser_out", 8'h00); observe(8'(ser_out));
    tick = 1'b0; cyc(); check_all("t6_no_done", 8'h00, 1'b0, 1'b0);
    step = 1'b1; dir = 1'b1; mode = 2'b01; ser_in = 1'b1; cyc(); step = 1'b0;
    check_all("t6_clean_step", 8'h80, 1'b0, 1'b0);

    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover: observed %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
